// File: rtl/mac_psum_requant_if.sv
// rtl/mac_psum_requant_if.sv - partial-sum input stream and requantized output stream
interface mac_psum_requant_if #(
    parameter int PSUM_W = 16,
    parameter int OUT_W  = 8
);
    logic [PSUM_W-1:0] psum_in;
    logic              psum_valid;
    logic              acc_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output psum_in, psum_valid, out_ready,
        input  acc_ready, out_data, out_valid
    );

    modport slave (
        input  psum_in, psum_valid, out_ready,
        output acc_ready, out_data, out_valid
    );
endinterface

// File: rtl/mac_psum_requant.sv
// rtl/mac_psum_requant.sv - accumulate MAC partial sums from a bias, requantize to int8, stream out
module mac_psum_requant #(
    parameter int PSUM_W = 16,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 8,
    parameter int OUT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_beats,
    input  logic [CNT_W-1:0]  cfg_outputs,
    input  logic [PSUM_W-1:0] cfg_bias,
    input  logic [4:0]        cfg_shift,
    input  logic              cfg_relu,
    mac_psum_requant_if.slave io,
    output logic              busy,
    output logic              done,
    output logic              drop_err,
    output logic              sat_err
);
    localparam int AW1 = ACC_W + 1;
    localparam logic signed [AW1-1:0] OMAX_W = AW1'((1 << (OUT_W-1)) - 1);
    localparam logic signed [AW1-1:0] OMIN_W = AW1'(-(1 << (OUT_W-1)));
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, REQUANT, OUTPUT} state_t;
    state_t state_q, state_d;

    logic [CNT_W-1:0]  beats_q, outputs_q, beat_cnt_q, out_cnt_q;
    logic [PSUM_W-1:0] bias_q;
    logic [4:0]        shift_q;
    logic              relu_q;
    logic [ACC_W-1:0]  acc_q;
    logic [OUT_W-1:0]  out_data_q;
    logic              out_valid_q, done_q, drop_err_q, sat_err_q;

    logic                  accept, handshake, last_beat, last_out;
    logic signed [AW1-1:0] sum_w, half_w, rnd_w, shr_w, rl_w;
    logic [ACC_W-1:0]      acc_next, bias_ext;
    logic                  acc_sat, q_hi, q_lo;
    logic [OUT_W-1:0]      q_data;

    assign io.acc_ready = (state_q == ACCUM);
    assign io.out_data  = out_data_q;
    assign io.out_valid = out_valid_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign drop_err     = drop_err_q;
    assign sat_err      = sat_err_q;

    assign accept    = io.psum_valid && (state_q == ACCUM);
    assign handshake = out_valid_q && io.out_ready;
    assign last_beat = (beat_cnt_q + CNT_W'(1)) == beats_q;
    assign last_out  = (out_cnt_q + CNT_W'(1)) == outputs_q;
    assign bias_ext  = {{(ACC_W-PSUM_W){bias_q[PSUM_W-1]}}, bias_q};

    // One guard bit above the accumulator catches overflow before clamping.
    always_comb begin
        sum_w    = {acc_q[ACC_W-1], acc_q} + {{(AW1-PSUM_W){io.psum_in[PSUM_W-1]}}, io.psum_in};
        acc_sat  = sum_w[ACC_W] != sum_w[ACC_W-1];
        acc_next = acc_sat ? (sum_w[ACC_W] ? ACC_MIN : ACC_MAX) : sum_w[ACC_W-1:0];
    end

    // Round half up, shift, optional ReLU, then clamp into the output range.
    always_comb begin
        half_w = '0;
        if (shift_q != 5'd0)
            half_w = AW1'(1) << (shift_q - 5'd1);
        rnd_w  = {acc_q[ACC_W-1], acc_q} + half_w;
        shr_w  = rnd_w >>> shift_q;
        rl_w   = (relu_q && shr_w[AW1-1]) ? '0 : shr_w;
        q_hi   = rl_w > OMAX_W;
        q_lo   = rl_w < OMIN_W;
        q_data = q_hi ? OMAX_W[OUT_W-1:0] : (q_lo ? OMIN_W[OUT_W-1:0] : rl_w[OUT_W-1:0]);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (accept && last_beat) state_d = REQUANT;
            REQUANT: state_d = OUTPUT;
            OUTPUT:  if (handshake) state_d = last_out ? IDLE : ACCUM;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beats_q     <= '0;
            outputs_q   <= '0;
            bias_q      <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            acc_q       <= '0;
            beat_cnt_q  <= '0;
            out_cnt_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            drop_err_q  <= 1'b0;
            sat_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            if (io.psum_valid && !io.acc_ready)
                drop_err_q <= 1'b1;
            case (state_q)
                IDLE: if (start) begin
                    beats_q    <= (cfg_beats == '0) ? CNT_W'(1) : cfg_beats;
                    outputs_q  <= (cfg_outputs == '0) ? CNT_W'(1) : cfg_outputs;
                    bias_q     <= cfg_bias;
                    shift_q    <= cfg_shift;
                    relu_q     <= cfg_relu;
                    acc_q      <= {{(ACC_W-PSUM_W){cfg_bias[PSUM_W-1]}}, cfg_bias};
                    beat_cnt_q <= '0;
                    out_cnt_q  <= '0;
                    drop_err_q <= 1'b0;
                    sat_err_q  <= 1'b0;
                end
                ACCUM: if (accept) begin
                    acc_q      <= acc_next;
                    beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                    if (acc_sat) sat_err_q <= 1'b1;
                end
                REQUANT: begin
                    out_data_q  <= q_data;
                    out_valid_q <= 1'b1;
                    if (q_hi || q_lo) sat_err_q <= 1'b1;
                end
                OUTPUT: if (handshake) begin
                    out_valid_q <= 1'b0;
                    out_cnt_q   <= out_cnt_q + CNT_W'(1);
                    if (last_out) begin
                        done_q <= 1'b1;
                    end else begin
                        acc_q      <= bias_ext;
                        beat_cnt_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
